// File: rtl/me_pkg.sv
// me_pkg
//   Shared constants and state encoding for the motion-estimation block
//   feeder and its reference-row store.
//   No ports: imported by me_ref_row_buf and me_block_feeder.
package me_pkg;

   localparam int PIX_W      = 8;    // one luma pixel
   localparam int CUR_W      = 64;   // one current-block row / one load beat
   localparam int REF_W      = 184;  // one 23-pixel search-window row
   localparam int SAD_W      = 14;
   localparam int MV_W       = 4;
   localparam int LOAD_BEATS = 77;   // 8 current rows + 23 x 3 reference segments

   // Reported SAD when the core never answers.
   localparam logic [SAD_W-1:0] SAD_TIMEOUT_VAL = 14'h3FFF;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      STREAM,
      WAIT_RES,
      RESULT
   } state_t;

endpackage

// File: rtl/me_ref_row_buf.sv
// me_ref_row_buf
//   Search-window store: ROWS rows of REF_W bits, written one 64-bit
//   segment at a time and read combinationally by row index.
//   Ports:
//     clk      clock
//     wr_en    write one segment this cycle
//     wr_row   row being written
//     wr_seg   0: pixels 0..7, 1: pixels 8..15, 2: pixels 16..22
//     wr_data  load beat; for segment 2 the last byte is dropped
//     rd_row   row being read
//     rd_data  contents of rd_row
module me_ref_row_buf
   import me_pkg::*;
#(
   parameter int ROWS  = 23,
   parameter int IDX_W = $clog2(ROWS)
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_row,
   input  logic [1:0]       wr_seg,
   input  logic [CUR_W-1:0] wr_data,
   input  logic [IDX_W-1:0] rd_row,
   output logic [REF_W-1:0] rd_data
);

   // Width of the third segment: 7 pixels, i.e. a beat minus one pixel.
   localparam int TAIL_W = REF_W - 2*CUR_W;

   logic [REF_W-1:0] mem [ROWS];

   // Contents are not reset; an aborted load is simply overwritten.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         case (wr_seg)
            2'd0:    mem[wr_row][REF_W-1 -: CUR_W]       <= wr_data;
            2'd1:    mem[wr_row][REF_W-CUR_W-1 -: CUR_W] <= wr_data;
            default: mem[wr_row][TAIL_W-1:0]             <= wr_data[CUR_W-1:PIX_W];
         endcase
      end
   end

   assign rd_data = mem[rd_row];

endmodule

// File: rtl/me_block_feeder.sv
// me_block_feeder
//   Buffers one 8x8 current block and its 23x23 search window from 64-bit
//   load beats, streams them row by row into the motion-estimation core,
//   then holds the core's minimum-SAD answer (or a timeout marker) behind
//   a valid/ready handshake.
//   Ports:
//     clk, rst                     clock, asynchronous active-high reset
//     ld_valid/ld_ready/ld_data    load beats (8 current rows, then 23 x 3
//                                  reference segments)
//     strm_first                   pulse with the first streamed row
//     crt_valid/crt_row            current-block row, stream cycles 0..7
//     ref_valid/ref_row            search-window row, stream cycles 0..22
//     sad_en/sad_min/mv_x_in/mv_y_in  core result strobe and values
//     res_valid/res_ready          result handshake
//     res_sad/res_mv_x/res_mv_y    captured result
//     res_timeout                  result came from the timeout, not the core
module me_block_feeder
   import me_pkg::*;
#(
   parameter int CUR_ROWS    = 8,
   parameter int REF_ROWS    = 23,
   parameter int RES_TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ld_valid,
   output logic             ld_ready,
   input  logic [CUR_W-1:0] ld_data,
   output logic             strm_first,
   output logic             crt_valid,
   output logic [CUR_W-1:0] crt_row,
   output logic             ref_valid,
   output logic [REF_W-1:0] ref_row,
   input  logic             sad_en,
   input  logic [SAD_W-1:0] sad_min,
   input  logic [MV_W-1:0]  mv_x_in,
   input  logic [MV_W-1:0]  mv_y_in,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [SAD_W-1:0] res_sad,
   output logic [MV_W-1:0]  res_mv_x,
   output logic [MV_W-1:0]  res_mv_y,
   output logic             res_timeout
);

   localparam int CUR_IW = $clog2(CUR_ROWS);
   localparam int REF_IW = $clog2(REF_ROWS);
   localparam int BEAT_W = $clog2(LOAD_BEATS);
   localparam int TMO_W  = $clog2(RES_TIMEOUT);

   localparam logic [BEAT_W-1:0] CUR_BEATS  = BEAT_W'(CUR_ROWS);
   localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(CUR_ROWS + 3*REF_ROWS - 1);
   localparam logic [REF_IW-1:0] LAST_ROW   = REF_IW'(REF_ROWS - 1);
   localparam logic [REF_IW-1:0] CUR_ROWS_T = REF_IW'(CUR_ROWS);
   localparam logic [TMO_W-1:0]  LAST_TICK  = TMO_W'(RES_TIMEOUT - 1);

   state_t              state_reg, state_next;
   logic [BEAT_W-1:0]   beat_reg;
   logic [1:0]          seg_reg;
   logic [REF_IW-1:0]   row_reg;
   logic [REF_IW-1:0]   t_reg;
   logic [TMO_W-1:0]    tick_reg;
   logic [CUR_W-1:0]    crt_mem [CUR_ROWS];
   logic [REF_W-1:0]    ref_rd;

   logic ld_fire, load_cur, last_beat, stream_last, tick_expired;

   assign ld_ready     = (state_reg == IDLE) || (state_reg == LOAD);
   assign res_valid    = (state_reg == RESULT);
   assign ld_fire      = ld_valid && ld_ready;
   assign load_cur     = (beat_reg < CUR_BEATS);
   assign last_beat    = (beat_reg == LAST_BEAT);
   assign stream_last  = (t_reg == LAST_ROW);
   assign tick_expired = (tick_reg == LAST_TICK);

   me_ref_row_buf #(
      .ROWS (REF_ROWS)
   ) u_ref_buf (
      .clk     (clk),
      .wr_en   (ld_fire && !load_cur),
      .wr_row  (row_reg),
      .wr_seg  (seg_reg),
      .wr_data (ld_data),
      .rd_row  (t_reg),
      .rd_data (ref_rd)
   );

   always_ff @(posedge clk) begin
      if (ld_fire && load_cur) begin
         crt_mem[beat_reg[CUR_IW-1:0]] <= ld_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // sad_en takes priority over an expiring timeout.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:     if (ld_fire)                state_next = LOAD;
         LOAD:     if (ld_fire && last_beat)   state_next = STREAM;
         STREAM:   if (stream_last)            state_next = WAIT_RES;
         WAIT_RES: if (sad_en || tick_expired) state_next = RESULT;
         RESULT:   if (res_ready)              state_next = IDLE;
         default:                              state_next = IDLE;
      endcase
   end

   // Beat, segment and row counters. The reference row/segment pair is
   // tracked incrementally so no divide-by-3 is needed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat_reg <= '0;
         seg_reg  <= '0;
         row_reg  <= '0;
      end else if (ld_fire) begin
         if (last_beat) begin
            beat_reg <= '0;
            seg_reg  <= '0;
            row_reg  <= '0;
         end else begin
            beat_reg <= beat_reg + 1'b1;
            if (!load_cur) begin
               if (seg_reg == 2'd2) begin
                  seg_reg <= '0;
                  row_reg <= row_reg + 1'b1;
               end else begin
                  seg_reg <= seg_reg + 1'b1;
               end
            end
         end
      end
   end

   // tick_reg is 0 in the first WAIT_RES cycle, i.e. the cycle that
   // presents the last window row, and expires RES_TIMEOUT cycles later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         t_reg    <= '0;
         tick_reg <= '0;
      end else begin
         t_reg    <= (state_reg == STREAM && !stream_last) ? t_reg + 1'b1 : '0;
         tick_reg <= (state_reg == WAIT_RES) ? tick_reg + 1'b1 : '0;
      end
   end

   // Stream outputs lag the counter by one edge: row t is registered at
   // the end of STREAM cycle t.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         strm_first <= 1'b0;
         crt_valid  <= 1'b0;
         crt_row    <= '0;
         ref_valid  <= 1'b0;
         ref_row    <= '0;
      end else if (state_reg == STREAM) begin
         strm_first <= (t_reg == '0);
         ref_valid  <= 1'b1;
         ref_row    <= ref_rd;
         crt_valid  <= (t_reg < CUR_ROWS_T);
         crt_row    <= (t_reg < CUR_ROWS_T) ? crt_mem[t_reg[CUR_IW-1:0]] : '0;
      end else begin
         strm_first <= 1'b0;
         crt_valid  <= 1'b0;
         crt_row    <= '0;
         ref_valid  <= 1'b0;
         ref_row    <= '0;
      end
   end

   // Result data is only written in WAIT_RES, so it stays stable through
   // RESULT and remains readable after the handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_sad     <= '0;
         res_mv_x    <= '0;
         res_mv_y    <= '0;
         res_timeout <= 1'b0;
      end else if (state_reg == WAIT_RES) begin
         if (sad_en) begin
            res_sad     <= sad_min;
            res_mv_x    <= mv_x_in;
            res_mv_y    <= mv_y_in;
            res_timeout <= 1'b0;
         end else if (tick_expired) begin
            res_sad     <= SAD_TIMEOUT_VAL;
            res_mv_x    <= '0;
            res_mv_y    <= '0;
            res_timeout <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_me_block_feeder.sv
// tb_me_block_feeder
//   Self-checking bench for me_block_feeder. Loads are driven beat by beat;
//   expected stream rows and results are queued as stimulus is driven and
//   compared when the design presents them.
module tb_me_block_feeder;

   logic          clk = 1'b0;
   logic          rst;
   logic          ld_valid;
   logic          ld_ready;
   logic [63:0]   ld_data;
   logic          strm_first;
   logic          crt_valid;
   logic [63:0]   crt_row;
   logic          ref_valid;
   logic [183:0]  ref_row;
   logic          sad_en;
   logic [13:0]   sad_min;
   logic [3:0]    mv_x_in;
   logic [3:0]    mv_y_in;
   logic          res_valid;
   logic          res_ready;
   logic [13:0]   res_sad;
   logic [3:0]    res_mv_x;
   logic [3:0]    res_mv_y;
   logic          res_timeout;

   typedef struct packed {
      logic [13:0] sad;
      logic [3:0]  x;
      logic [3:0]  y;
      logic        tmo;
   } res_t;

   int errors = 0;
   int checks = 0;

   logic [183:0] exp_ref_q [$];
   logic [63:0]  exp_crt_q [$];
   res_t         exp_res_q [$];

   always #5 clk = ~clk;

   me_block_feeder dut (
      .clk         (clk),
      .rst         (rst),
      .ld_valid    (ld_valid),
      .ld_ready    (ld_ready),
      .ld_data     (ld_data),
      .strm_first  (strm_first),
      .crt_valid   (crt_valid),
      .crt_row     (crt_row),
      .ref_valid   (ref_valid),
      .ref_row     (ref_row),
      .sad_en      (sad_en),
      .sad_min     (sad_min),
      .mv_x_in     (mv_x_in),
      .mv_y_in     (mv_y_in),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_sad     (res_sad),
      .res_mv_x    (res_mv_x),
      .res_mv_y    (res_mv_y),
      .res_timeout (res_timeout)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Loads 77 beats and queues the expected stream. mode 0: all 8'hFA with
   // beat 10 = 64'h0102030405060708; mode 1: random. Starts and ends at a
   // falling edge; ends one cycle after the last beat was accepted.
   task automatic load_block(input int mode, input bit stall, input bit pulse_sad);
      logic [63:0] beats [77];
      int w;
      for (int b = 0; b < 77; b++) begin
         beats[b] = (mode == 0) ? 64'hFAFA_FAFA_FAFA_FAFA : {$urandom(), $urandom()};
      end
      if (mode == 0) beats[10] = 64'h0102_0304_0506_0708;
      for (int b = 0; b < 77; b++) begin
         if (stall && b == 30) begin
            ld_valid = 1'b0;
            repeat (3) @(negedge clk);
            checks++;
            if (ld_ready !== 1'b1) begin
               errors++;
               $display("FAIL ld_ready_stall: got %b want 1", ld_ready);
            end
         end
         ld_valid = 1'b1;
         ld_data  = beats[b];
         sad_en   = pulse_sad && (b == 50);
         sad_min  = 14'd5;
         mv_x_in  = 4'd7;
         mv_y_in  = 4'd7;
         w = 0;
         while (ld_ready !== 1'b1 && w < 10) begin
            @(negedge clk);
            w++;
         end
         if (w >= 10) begin
            errors++;
            checks++;
            $display("FAIL load_wait: ld_ready stuck at %b, want 1 (beat %0d)", ld_ready, b);
            ld_valid = 1'b0;
            sad_en   = 1'b0;
            return;
         end
         @(negedge clk);
      end
      ld_valid = 1'b0;
      sad_en   = 1'b0;
      checks++;
      if (ld_ready !== 1'b0) begin
         errors++;
         $display("FAIL ld_ready_drop: got %b want 0 after beat 76", ld_ready);
      end
      for (int r = 0; r < 8; r++) exp_crt_q.push_back(beats[r]);
      for (int r = 0; r < 23; r++) begin
         exp_ref_q.push_back({beats[8+3*r], beats[9+3*r], beats[10+3*r][63:8]});
      end
      $display("load: 77 beats accepted (mode %0d, stall %0d)", mode, stall);
   endtask

   // Checks 23 streamed cycles; ends at the falling edge showing row 22.
   task automatic stream_check(input bit pulse_sad, output logic [183:0] row0);
      logic [183:0] er;
      logic [63:0]  ec;
      logic [2:0]   flags_exp;
      row0 = '0;
      checks++;
      if (ref_valid !== 1'b0) begin
         errors++;
         $display("FAIL stream_latency: ref_valid got %b want 0 before first row", ref_valid);
      end
      for (int i = 0; i < 23; i++) begin
         sad_en  = pulse_sad && (i == 5);
         sad_min = 14'd9;
         @(negedge clk);
         sad_en = 1'b0;
         if (i == 0) row0 = ref_row;
         flags_exp = {1'b1, (i == 0), (i < 8)};
         checks++;
         if ({ref_valid, strm_first, crt_valid} !== flags_exp) begin
            errors++;
            $display("FAIL stream_flags[%0d]: got %b want %b", i,
                     {ref_valid, strm_first, crt_valid}, flags_exp);
         end
         checks++;
         if (exp_ref_q.size() == 0) begin
            errors++;
            $display("FAIL ref_row[%0d]: got %h want <nothing queued>", i, ref_row);
         end else begin
            er = exp_ref_q.pop_front();
            if (ref_row !== er) begin
               errors++;
               $display("FAIL ref_row[%0d]: got %h want %h", i, ref_row, er);
            end
         end
         checks++;
         if (i < 8) begin
            if (exp_crt_q.size() == 0) begin
               errors++;
               $display("FAIL crt_row[%0d]: got %h want <nothing queued>", i, crt_row);
            end else begin
               ec = exp_crt_q.pop_front();
               if (crt_row !== ec) begin
                  errors++;
                  $display("FAIL crt_row[%0d]: got %h want %h", i, crt_row, ec);
               end
            end
         end else if (crt_row !== 64'h0) begin
            errors++;
            $display("FAIL crt_row[%0d]: got %h want 0", i, crt_row);
         end
         checks++;
         if (res_valid !== 1'b0) begin
            errors++;
            $display("FAIL res_valid_stream[%0d]: got %b want 0", i, res_valid);
         end
      end
      $display("stream: 23 rows presented");
   endtask

   task automatic test_reset();
      rst = 1'b1; ld_valid = 1'b0; ld_data = '0; sad_en = 1'b0;
      sad_min = '0; mv_x_in = '0; mv_y_in = '0; res_ready = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({ld_ready, strm_first, crt_valid, ref_valid, res_valid, res_timeout} !== 6'b100000) begin
         errors++;
         $display("FAIL reset_flags: got %b want 100000",
                  {ld_ready, strm_first, crt_valid, ref_valid, res_valid, res_timeout});
      end
      checks++;
      if ({crt_row, ref_row, res_sad, res_mv_x, res_mv_y} !== '0) begin
         errors++;
         $display("FAIL reset_data: got crt=%h ref=%h sad=%h mv=%h,%h want all 0",
                  crt_row, ref_row, res_sad, res_mv_x, res_mv_y);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({ld_ready, res_valid} !== 2'b10) begin
         errors++;
         $display("FAIL idle_after_reset: got %b want 10", {ld_ready, res_valid});
      end
   endtask

   task automatic test_fill_stream();
      logic [183:0] row0;
      logic [183:0] want0;
      want0 = {64'hFAFA_FAFA_FAFA_FAFA, 64'hFAFA_FAFA_FAFA_FAFA, 56'h01_0203_0405_0607};
      load_block(0, 1'b0, 1'b0);
      stream_check(1'b0, row0);
      checks++;
      if (row0 !== want0) begin
         errors++;
         $display("FAIL row0_segment2: got %h want %h", row0, want0);
      end
   endtask

   task automatic test_result_hold();
      res_t er;
      res_t got;
      @(negedge clk);
      checks++;
      if ({ref_valid, res_valid} !== 2'b00) begin
         errors++;
         $display("FAIL wait_entry: got ref_valid,res_valid=%b want 00", {ref_valid, res_valid});
      end
      sad_en = 1'b1; sad_min = 14'd37; mv_x_in = 4'd3; mv_y_in = 4'd12;
      exp_res_q.push_back('{sad: 14'd37, x: 4'd3, y: 4'd12, tmo: 1'b0});
      @(negedge clk);
      sad_en = 1'b0; sad_min = 14'd999; mv_x_in = 4'd9; mv_y_in = 4'd1;
      er = exp_res_q.pop_front();
      for (int c = 0; c < 5; c++) begin
         got = {res_sad, res_mv_x, res_mv_y, res_timeout};
         checks++;
         if (res_valid !== 1'b1 || got !== er) begin
            errors++;
            $display("FAIL result_hold[%0d]: got valid=%b %h want valid=1 %h", c, res_valid, got, er);
         end
         sad_en = (c == 1);
         @(negedge clk);
      end
      sad_en = 1'b0;
      $display("result: sad=%0d mv=(%0d,%0d) timeout=%0d", res_sad, res_mv_x, res_mv_y, res_timeout);
   endtask

   // Handshake while a beat is already offered: the beat must wait for IDLE.
   task automatic test_back_to_back();
      logic [183:0] row0;
      res_ready = 1'b1;
      ld_valid  = 1'b1;
      ld_data   = 64'hDEAD_BEEF_0BAD_F00D;
      checks++;
      if ({res_valid, ld_ready} !== 2'b10) begin
         errors++;
         $display("FAIL handshake_cycle: got res_valid,ld_ready=%b want 10", {res_valid, ld_ready});
      end
      @(negedge clk);
      res_ready = 1'b0;
      checks++;
      if ({res_valid, ld_ready} !== 2'b01) begin
         errors++;
         $display("FAIL after_handshake: got res_valid,ld_ready=%b want 01", {res_valid, ld_ready});
      end
      checks++;
      if (res_sad !== 14'd37) begin
         errors++;
         $display("FAIL res_sad_kept: got %0d want 37", res_sad);
      end
      load_block(1, 1'b0, 1'b1);
      stream_check(1'b1, row0);
   endtask

   task automatic test_timeout();
      int n;
      res_t er;
      res_t got;
      exp_res_q.push_back('{sad: 14'h3FFF, x: 4'd0, y: 4'd0, tmo: 1'b1});
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (res_valid !== 1'b1 && n < 100);
      checks++;
      if (n != 64) begin
         errors++;
         $display("FAIL timeout_latency: got %0d cycles want 64", n);
      end
      er  = exp_res_q.pop_front();
      got = {res_sad, res_mv_x, res_mv_y, res_timeout};
      checks++;
      if (got !== er) begin
         errors++;
         $display("FAIL timeout_result: got %h want %h", got, er);
      end
      $display("result: sad=%h mv=(%0d,%0d) timeout=%0d", res_sad, res_mv_x, res_mv_y, res_timeout);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      checks++;
      if (res_valid !== 1'b0) begin
         errors++;
         $display("FAIL timeout_handshake: res_valid got %b want 0", res_valid);
      end
   endtask

   task automatic test_abort_reload();
      logic [183:0] row0;
      logic early;
      res_t er;
      res_t got;
      for (int b = 0; b <= 40; b++) begin
         ld_valid = 1'b1;
         ld_data  = {$urandom(), $urandom()};
         @(negedge clk);
      end
      ld_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({ld_ready, strm_first, crt_valid, ref_valid, res_valid, res_timeout} !== 6'b100000) begin
         errors++;
         $display("FAIL async_reset_flags: got %b want 100000",
                  {ld_ready, strm_first, crt_valid, ref_valid, res_valid, res_timeout});
      end
      checks++;
      if ({res_sad, res_mv_x, res_mv_y} !== 22'h0) begin
         errors++;
         $display("FAIL async_reset_result: got sad=%h mv=%h,%h want 0", res_sad, res_mv_x, res_mv_y);
      end
      @(negedge clk);
      rst = 1'b0;
      $display("reset: partial load of 41 beats aborted");
      load_block(1, 1'b1, 1'b0);
      stream_check(1'b0, row0);
      // sad_en arrives in the very cycle the timeout expires.
      early = 1'b0;
      for (int k = 1; k <= 63; k++) begin
         @(negedge clk);
         if (res_valid === 1'b1) early = 1'b1;
      end
      sad_en = 1'b1; sad_min = 14'h0ABC; mv_x_in = 4'd5; mv_y_in = 4'd10;
      exp_res_q.push_back('{sad: 14'h0ABC, x: 4'd5, y: 4'd10, tmo: 1'b0});
      @(negedge clk);
      sad_en = 1'b0;
      checks++;
      if (early !== 1'b0 || res_valid !== 1'b1) begin
         errors++;
         $display("FAIL sad_vs_timeout_valid: got early=%b res_valid=%b want 0,1", early, res_valid);
      end
      er  = exp_res_q.pop_front();
      got = {res_sad, res_mv_x, res_mv_y, res_timeout};
      checks++;
      if (got !== er) begin
         errors++;
         $display("FAIL sad_vs_timeout_result: got %h want %h", got, er);
      end
      $display("result: sad=%h mv=(%0d,%0d) timeout=%0d", res_sad, res_mv_x, res_mv_y, res_timeout);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      checks++;
      if ({res_valid, ld_ready} !== 2'b01) begin
         errors++;
         $display("FAIL final_handshake: got res_valid,ld_ready=%b want 01", {res_valid, ld_ready});
      end
   endtask

   initial begin
      test_reset();
      test_fill_stream();
      test_result_hold();
      test_back_to_back();
      test_timeout();
      test_abort_reload();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/me_block_feeder.md
Name: me_block_feeder

Overview:
- Drives one 8x8 current block and its 23x23 reference search window into the motion-estimation core.
- Collects the core's minimum-SAD result and returns it to the requester.
- Sits between the frame-buffer fetch logic, which pushes 64-bit pixel beats, and the `core` instance.
- Serialises buffered rows in exactly the cycle order the core consumes them, then holds the result behind a valid/ready handshake.

Parameters:
- CUR_ROWS, 8, current-block rows streamed (8 pixels per row, 64 bits).
- REF_ROWS, 23, search-window rows streamed (23 pixels per row, 184 bits).
- RES_TIMEOUT, 64, cycles to wait for sad_en after the last streamed row before giving up.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- ld_valid  in  1  load beat valid.
- ld_ready  out  1  feeder accepts a load beat.
- ld_data  in  64  8 pixels; pixel 0 in [63:56].
- strm_first  out  1  pulse on stream cycle 0.
- crt_valid  out  1  crt_row valid (stream cycles 0..7).
- crt_row  out  64  current-block row; top level fans it to crt_frame_0..15.
- ref_valid  out  1  ref_row valid (stream cycles 0..22).
- ref_row  out  184  window row; top level slices pre_frame_k = ref_row[(23-k)*8-1 -: 64].
- sad_en  in  1  core result strobe.
- sad_min  in  14  core minimum SAD.
- mv_x_in  in  4  core motion_vec_x_min.
- mv_y_in  in  4  core motion_vec_y_min.
- res_valid  out  1  result held.
- res_ready  in  1  requester takes result.
- res_sad  out  14  captured SAD.
- res_mv_x  out  4  captured x motion vector.
- res_mv_y  out  4  captured y motion vector.
- res_timeout  out  1  result is a timeout, not a core answer.

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous and active-high.
- Reset values: state IDLE, all counters 0. ld_ready=1. strm_first, crt_valid, ref_valid, res_valid, res_timeout = 0. crt_row, ref_row, res_sad, res_mv_x, res_mv_y = 0.

State IDLE:
- ld_ready=1.
- An accepted beat (ld_valid & ld_ready) stores to beat 0 and moves to LOAD.

State LOAD:
- ld_ready=1.
- 77 beats total, fixed order:
  - Beats 0..7: current rows 0..7.
  - Beats 8..76: reference row r = (b-8)/3, segment s = (b-8)%3. s0 gives pixels 0..7, s1 gives pixels 8..15, s2 gives pixels 16..22 from ld_data[63:8]; ld_data[7:0] is discarded.
- After the cycle in which beat 76 is accepted: ld_ready drops, state goes to STREAM.
- Beats are buffered in registers: 8x64 current plus 23x184 reference.

State STREAM:
- Counter t runs 0..22, one row per cycle with no stalls.
- Cycle t:
  - ref_valid=1, ref_row = reference row t.
  - crt_valid=(t<8), crt_row = current row t when t<8, else 0.
  - strm_first=(t==0).
- Outputs are registered; row t appears on the first clk edge after entry plus t.
- After t=22: ref_valid=0, ref_row=0, state goes to WAIT_RES, timeout counter cleared.

State WAIT_RES:
- First cycle with sad_en=1: capture sad_min, mv_x_in, mv_y_in into res_*; res_timeout=0; go to RESULT.
- If RES_TIMEOUT cycles pass with no sad_en: res_sad=14'h3FFF, res_mv_x=0, res_mv_y=0, res_timeout=1; go to RESULT.
- sad_en and the timeout expiring in the same cycle: sad_en wins.

State RESULT:
- res_valid=1; res_* stay stable until handshake.
- On res_valid & res_ready: res_valid=0 next cycle, go to IDLE. res_* data keep their values; only res_valid clears.
- ld_ready=0 throughout, so a beat offered in the handshake cycle is accepted at the earliest one cycle later, in IDLE.

Other rules:
- sad_en is ignored outside WAIT_RES.
- ld_valid is ignored whenever ld_ready=0.
- rst asserted in any state aborts immediately: buffers need not clear, and the partial load is discarded because the beat counter returns to 0.
- Throughput: one block per 77 + 23 + result latency + handshake cycles.

Decomposition:
- Shared package me_pkg holds:
  - Constants PIX_W=8, CUR_W=64, REF_W=184, SAD_W=14, MV_W=4, LOAD_BEATS=77.
  - The state enum {IDLE, LOAD, STREAM, WAIT_RES, RESULT}.
  - SAD_TIMEOUT_VAL=14'h3FFF.
- One natural sub-module, me_ref_row_buf: the 23x184 reference store, written through the segment-select write port and read by row index. Everything else stays in the top FSM.

Test Plan:
1. Load current rows all 8'hFA and reference rows all 8'hFA, with ld_valid held high.
   -> ld_ready falls after beat 76.
   -> 23 consecutive ref_valid cycles, the first with strm_first=1.
   -> crt_valid high for exactly 8 cycles, crt_row=64'hFAFA_FAFA_FAFA_FAFA.
2. Beat 10 (row 0, s2) = 64'h0102030405060708.
   -> ref_row of row 0 has bits [55:0] = 56'h01020304050607; byte 8'h08 does not appear.
3. In WAIT_RES, drive sad_en=1 with sad_min=14'd37, mv=(3,12), and hold res_ready=0 for 5 cycles.
   -> res_valid=1, res_sad=37, res_mv_x=3, res_mv_y=12, res_timeout=0, all stable for 5 cycles.
   -> res_valid drops one cycle after res_ready=1.
4. Never assert sad_en.
   -> Exactly 64 cycles after the last ref_valid: res_valid=1, res_sad=14'h3FFF, res_timeout=1.
5. Pulse sad_en during LOAD and STREAM.
   -> Ignored; no res_valid until WAIT_RES.
6. Assert rst after beat 40, then reload 77 fresh beats.
   -> All outputs return to reset values asynchronously.
   -> The stream carries only the new data.
   -> ld_valid stalls mid-load (ld_valid=0 for 3 cycles) only lengthen LOAD.
